// File: rtl/color_classifier.sv
// color_classifier
//   Scans a 160x120 RGB332 frame buffer after each camera frame-done,
//   counts red-, green- and blue-dominant pixels and reports the frame's
//   dominant colour.
//
// Ports
//   clk, rst          : system clock, asynchronous active-high reset
//   frame_done        : camera frame-complete (foreign clock domain)
//   mem_px_addr       : frame buffer read address
//   mem_px_data       : RGB332 pixel, valid one clk after its address
//   busy              : scan in progress
//   result_valid      : one-clk pulse when result updates
//   result            : 00 none, 01 red, 10 green, 11 blue
//
// Build option
//   COLOR_CLASS_SAT_EN : count a pixel only if max-min of its channels >= 2
//                        (rejects grey/white/black). Undefined: dominance only.
module color_classifier #(
   parameter int AW        = 15,
   parameter int NPIX      = 19200,
   parameter int CW        = 15,
   parameter int MIN_COUNT = 1920
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_done,
   output logic [AW-1:0] mem_px_addr,
   input  logic [7:0]    mem_px_data,
   output logic          busy,
   output logic          result_valid,
   output logic [1:0]    result
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DECIDE} state_t;

   state_t        state;
   logic          fd_s1, fd_s2, fd_s3;
   logic [1:0]    sync_fill;
   logic          armed;
   logic          fd_rise;
   logic          px_vld;
   logic [CW-1:0] cnt_r, cnt_g, cnt_b;

   // frame_done synchroniser + edge detector. sync_fill masks the cycles
   // where the synchroniser still holds its reset value, so armed only
   // sets once a genuine low level of frame_done has been seen. This keeps
   // a frame_done already high at reset release from starting a scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fd_s1     <= 1'b0;
         fd_s2     <= 1'b0;
         fd_s3     <= 1'b0;
         sync_fill <= '0;
         armed     <= 1'b0;
         fd_rise   <= 1'b0;
      end else begin
         fd_s1     <= frame_done;
         fd_s2     <= fd_s1;
         fd_s3     <= fd_s2;
         sync_fill <= {sync_fill[0], 1'b1};
         armed     <= armed | (sync_fill[1] & ~fd_s2);
         fd_rise   <= fd_s2 & ~fd_s3 & armed;
      end
   end

   // Pixel classification; B is widened to 3 bits by repeating its MSB.
   logic [2:0] px_r, px_g, px_b3;
   logic       is_r, is_g, is_b, spread_ok;
`ifdef COLOR_CLASS_SAT_EN
   logic [2:0] px_max, px_min;
`endif

   always_comb begin
      px_r  = mem_px_data[7:5];
      px_g  = mem_px_data[4:2];
      px_b3 = {mem_px_data[1:0], mem_px_data[1]};
      is_r  = (px_r > px_g)  && (px_r > px_b3);
      is_g  = (px_g > px_r)  && (px_g > px_b3);
      is_b  = (px_b3 > px_r) && (px_b3 > px_g);
`ifdef COLOR_CLASS_SAT_EN
      px_max = px_r;
      if (px_g  > px_max) px_max = px_g;
      if (px_b3 > px_max) px_max = px_b3;
      px_min = px_r;
      if (px_g  < px_min) px_min = px_g;
      if (px_b3 < px_min) px_min = px_b3;
      spread_ok = (px_max - px_min) >= 3'd2;
`else
      spread_ok = 1'b1;
`endif
   end

   // Winner: largest count, ties resolved red > green > blue.
   logic [CW-1:0] win_cnt;
   logic [1:0]    win_col, decision;

   always_comb begin
      if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
         win_cnt = cnt_r;
         win_col = 2'b01;
      end else if (cnt_g >= cnt_b) begin
         win_cnt = cnt_g;
         win_col = 2'b10;
      end else begin
         win_cnt = cnt_b;
         win_col = 2'b11;
      end
      decision = (win_cnt < CW'(MIN_COUNT)) ? 2'b00 : win_col;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         mem_px_addr  <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= 2'b00;
         px_vld       <= 1'b0;
         cnt_r        <= '0;
         cnt_g        <= '0;
         cnt_b        <= '0;
      end else begin
         result_valid <= 1'b0;
         // Data returns one clk after its address, so the SCAN state
         // delayed by one cycle marks a valid pixel (incl. the DRAIN cycle).
         px_vld <= (state == SCAN);
         if (px_vld && spread_ok) begin
            if (is_r && !(&cnt_r)) cnt_r <= cnt_r + 1'b1;
            if (is_g && !(&cnt_g)) cnt_g <= cnt_g + 1'b1;
            if (is_b && !(&cnt_b)) cnt_b <= cnt_b + 1'b1;
         end
         case (state)
            IDLE: begin
               if (fd_rise) begin
                  cnt_r       <= '0;
                  cnt_g       <= '0;
                  cnt_b       <= '0;
                  mem_px_addr <= '0;
                  busy        <= 1'b1;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               if (mem_px_addr == AW'(NPIX - 1)) state <= DRAIN;
               else mem_px_addr <= mem_px_addr + 1'b1;
            end
            DRAIN: state <= DECIDE;
            DECIDE: begin
               result       <= decision;
               result_valid <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_color_classifier.sv
module tb_color_classifier;
   localparam int AW = 8, NPIX = 200, CW = 8, MIN_COUNT = 20;
`ifdef COLOR_CLASS_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam logic [1:0] GREY_EXP = SAT ? 2'b00 : 2'b11;

   logic          clk = 1'b0;
   logic          rst, frame_done;
   logic [AW-1:0] mem_px_addr;
   logic [7:0]    mem_px_data;
   logic          busy, result_valid;
   logic [1:0]    result;

   logic [7:0] mem [NPIX];
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   // Synchronous-read frame buffer model
   always @(posedge clk)
      mem_px_data <= (int'(mem_px_addr) < NPIX) ? mem[int'(mem_px_addr)] : 8'h00;

   color_classifier #(.AW(AW), .NPIX(NPIX), .CW(CW), .MIN_COUNT(MIN_COUNT)) dut (
      .clk(clk), .rst(rst), .frame_done(frame_done),
      .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
      .busy(busy), .result_valid(result_valid), .result(result)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fill(input int na, input logic [7:0] pa, input logic [7:0] pb);
      for (int p = 0; p < NPIX; p++) mem[p] = (p < na) ? pa : pb;
   endtask

   // Reference: classify each pixel from its channel values, tally, pick winner.
   function automatic logic [1:0] model_result();
      int cnt[3];
      int v[3];
      int px, mx, mn, nmx, idx, best;
      cnt = '{0, 0, 0};
      for (int p = 0; p < NPIX; p++) begin
         px   = int'(mem[p]);
         v[0] = px / 32;
         v[1] = (px / 4) % 8;
         v[2] = (px % 4) * 2 + (px % 4) / 2;
         mx = v[0]; mn = v[0]; idx = 0;
         for (int c = 1; c < 3; c++) begin
            if (v[c] > mx) begin mx = v[c]; idx = c; end
            if (v[c] < mn) mn = v[c];
         end
         nmx = 0;
         for (int c = 0; c < 3; c++) if (v[c] == mx) nmx++;
         if (nmx == 1 && (!SAT || mx - mn >= 2)) cnt[idx]++;
      end
      best = 0;
      for (int c = 1; c < 3; c++) if (cnt[c] > cnt[best]) best = c;
      return (cnt[best] < MIN_COUNT) ? 2'd0 : 2'(best + 1);
   endfunction

   // Pulse frame_done, check start latency, scan length and the result pulse.
   // extra: re-pulse frame_done mid-scan (must be ignored).
   task automatic run_frame(input string tag, input bit extra, output logic [1:0] res);
      int  n;
      bit  seen;
      @(negedge clk);
      frame_done = 1'b1;
      seen = 1'b0;
      for (n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         if (busy) begin seen = 1'b1; break; end
      end
      chk({tag, " start_lat"}, n, 4);
      chk({tag, " start_addr"}, 32'(mem_px_addr), 0);
      frame_done = 1'b0;
      if (!seen) begin res = 2'bxx; return; end
      seen = 1'b0;
      for (n = 1; n <= NPIX + 10; n++) begin
         @(posedge clk); #1;
         if (extra && n == 20) frame_done = 1'b1;
         if (extra && n == 25) frame_done = 1'b0;
         if (result_valid) begin seen = 1'b1; break; end
      end
      chk({tag, " valid_lat"}, n, NPIX + 2);
      chk({tag, " busy_fall"}, 32'(busy), 0);
      chk({tag, " end_addr"}, 32'(mem_px_addr), NPIX - 1);
      res = result;
      @(posedge clk); #1;
      chk({tag, " valid_once"}, 32'(result_valid), 0);
   endtask

   typedef struct {
      int         na;
      logic [7:0] pa;
      logic [7:0] pb;
      logic [1:0] exp;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[9];
      logic [1:0] res;
      logic [7:0] pal[6];
      int         n, b, mode, k;
      logic [7:0] c;

      tbl[0] = '{NPIX, 8'hE0, 8'h00, 2'b01}; // all red
      tbl[1] = '{104,  8'h1C, 8'h03, 2'b10}; // green majority
      tbl[2] = '{104,  8'h03, 8'h1C, 2'b11}; // blue majority
      tbl[3] = '{10,   8'hE0, 8'h00, 2'b00}; // below MIN_COUNT
      tbl[4] = '{100,  8'hE0, 8'h1C, 2'b01}; // red/green tie -> red
      tbl[5] = '{NPIX, 8'h92, 8'h00, GREY_EXP}; // grey
      tbl[6] = '{100,  8'h1C, 8'h03, 2'b10}; // green/blue tie -> green
      tbl[7] = '{MIN_COUNT - 1, 8'hE0, 8'h00, 2'b00};
      tbl[8] = '{MIN_COUNT,     8'hE0, 8'h00, 2'b01};
      pal = '{8'hE0, 8'h1C, 8'h03, 8'h92, 8'h00, 8'hFF};

      rst = 1'b1;
      frame_done = 1'b0;
      fill(NPIX, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      chk("reset addr", 32'(mem_px_addr), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset valid", 32'(result_valid), 0);
      chk("reset result", 32'(result), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         fill(tbl[i].na, tbl[i].pa, tbl[i].pb);
         run_frame($sformatf("vec%0d", i), 1'b0, res);
         chk($sformatf("vec%0d result", i), 32'(res), 32'(tbl[i].exp));
      end

      // Abort mid-scan with reset (last result was red)
      fill(NPIX, 8'hE0, 8'h00);
      @(negedge clk);
      frame_done = 1'b1;
      n = 0;
      while (int'(mem_px_addr) != 50 && n < NPIX + 20) begin
         @(posedge clk); #1;
         n++;
         if (n == 6) frame_done = 1'b0;
      end
      chk("abort reached addr", 32'(mem_px_addr), 50);
      frame_done = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort addr", 32'(mem_px_addr), 0);
      chk("abort busy", 32'(busy), 0);
      chk("abort valid", 32'(result_valid), 0);
      chk("abort result", 32'(result), 0);
      repeat (2) @(negedge clk);
      chk("abort busy held", 32'(busy), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      fill(NPIX, 8'h1C, 8'h00);
      run_frame("recover", 1'b1, res);
      chk("recover result", 32'(res), 2'b10);
      b = 0;
      repeat (12) begin @(posedge clk); #1; if (busy) b++; end
      chk("no extra scan", b, 0);

      // frame_done already high when reset releases
      @(negedge clk);
      frame_done = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      b = 0;
      repeat (12) begin @(posedge clk); #1; if (busy) b++; end
      chk("fd high at reset", b, 0);
      @(negedge clk);
      frame_done = 1'b0;
      repeat (5) @(negedge clk);
      fill(NPIX, 8'hE0, 8'h00);
      run_frame("after high", 1'b0, res);
      chk("after high result", 32'(res), 2'b01);

      // Randomised frames against the reference model
      for (int f = 0; f < 10; f++) begin
         mode = $urandom_range(0, 2);
         k = $urandom_range(MIN_COUNT - 8, MIN_COUNT + 8);
         c = pal[$urandom_range(0, 2)];
         for (int p = 0; p < NPIX; p++) begin
            if (mode == 0)      mem[p] = 8'($urandom);
            else if (mode == 1) mem[p] = pal[$urandom_range(0, 5)];
            else                mem[p] = (p < k) ? c : 8'h00;
         end
         run_frame($sformatf("rnd%0d", f), 1'b0, res);
         chk($sformatf("rnd%0d result", f), 32'(res), 32'(model_result()));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
